nios_ram_arbiter: RTL
=====================

# nios_ram_arbiter

Two-requester arbiter that shares the single-port 4096×32 on-chip `nios_ram` between two Avalon-MM masters: the Nios II data master (port 0) and a DMA/peripheral master (port 1). It sits directly in front of the RAM's s1 interface, grants one transfer per clock, and returns read data one cycle later with `readdatavalid`. A lock input supports atomic read-modify-write sequences.

## Interface
- `ADDR_W`, 12, word address width (4096 words)
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `clk  in  1  system clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `mN_address  in  ADDR_W  word address (N = 0, 1)`
- `mN_byteenable  in  4  byte lanes for writes`
- `mN_read, mN_write  in  1  transfer request; both high = write (read ignored)`
- `mN_writedata  in  DATA_W  write data`
- `mN_lock  in  1  hold grant after this transfer`
- `mN_waitrequest  out  1  transfer not accepted this cycle`
- `mN_readdata  out  DATA_W  read data (shared `ram_readdata`)`
- `mN_readdatavalid  out  1  readdata valid for master N`
- `ram_address  out  ADDR_W`, `ram_byteenable  out  4`, `ram_chipselect  out  1`, `ram_write  out  1`, `ram_writedata  out  DATA_W`, `ram_clken  out  1`: RAM-side signals
- `ram_readdata  in  DATA_W  RAM output; valid one cycle after address`

## Operation
- Request: `reqN = mN_read | mN_write`. Grant is combinational from requests, the `last_grant` register, and the `lock_owner` register.
- Locked: only `lock_owner` can be granted; the other master waits regardless of its request.
- Unlocked with one requester: that master is granted.
- Unlocked with both requesting: arbitration depends on the configuration (see Configuration).
- Granted master: `waitrequest=0`; its address, byteenable, and writedata are muxed to the RAM. `ram_chipselect=1`. `ram_write = mN_write`.
- Non-granted requester: `waitrequest=1`. A master that is not requesting sees `waitrequest=0`.
- Idle cycle: `ram_chipselect=0`, `ram_write=0`. The address mux holds the port 0 selection.
- State registers:
  - `last_grant`: 1 bit, updated on every granted transfer.
  - `lock_owner`: {NONE, M0, M1}.
    - NONE→Mk when Mk is granted with `mk_lock=1`.
    - Mk→NONE when Mk is granted with `mk_lock=0`.
    - Mk→Mk otherwise; an idle cycle does not release the lock.
  - `rdv[1:0]`: read-valid pipeline.
- Read: `rdvN <= grantN & mN_read & ~mN_write`. `mN_readdatavalid = rdvN`. Both readdata outputs carry `ram_readdata`.
- `ram_clken` = 1 out of reset, 0 while `reset_n` is low.

## Timing
- Accept and RAM address in cycle T. Read data and `readdatavalid` in cycle T+1. Write completes in cycle T.
- Back-to-back transfers are allowed every cycle, including a read by one master followed by a write by the other.
- Throughput: one transfer per clock. Under round-robin contention each master gets 50%.
- Reset (async assert, sync deassert upstream):
  - `last_grant=1`, so M0 wins the first tie.
  - `lock_owner=NONE`, `rdv=0`.
  - While in reset, `mN_waitrequest=1` and `ram_chipselect=0`.
- Reset mid-transfer: a pending `readdatavalid` is dropped and the lock is released.
- Read+write asserted together: treated as a write, with no `readdatavalid`.

## Configuration
- `NIOS_RAM_ARB_RR_EN` defined: round-robin. On contention, grant the master that is not `last_grant`.
- Not defined: fixed priority. M0 always wins contention; `last_grant` is still maintained but unused. Lock behaviour is identical in both modes.

## Structure
- Package `nios_ram_arb_pkg`: `ADDR_W`/`DATA_W` defaults, the `lock_owner_t` enum {LOCK_NONE, LOCK_M0, LOCK_M1}, and the `READ_LATENCY=1` constant.
- Sub-module `nios_ram_arb_pick`: a 2-way picker with inputs `req[1:0]`, `last_grant`, `lock_owner` and a one-hot `grant[1:0]` output, holding the macro-selected policy. The top level holds the registers, muxes, and readdatavalid pipeline.

## Test plan
- Reset: with `reset_n=0`, both waitrequests are 1 and `ram_chipselect=0`. After release, M0 reads addr 0x010 (preloaded 0xDEADBEEF) and gets `m0_readdatavalid=1` with readdata 0xDEADBEEF exactly one cycle after accept.
- Contention, RR: both masters read continuously for 6 cycles. Grants alternate M0, M1, M0…; each master sees 3 readdatavalid pulses, each one cycle after its grant.
- Contention, fixed priority (macro undefined): same stimulus; M1 is held with `waitrequest=1` for all 6 cycles and M0 gets 6 grants.
- Byte write: M1 writes 0x12345678 to 0x7FF with byteenable 0b0101 over 0xFFFFFFFF. A following read of 0x7FF returns 0xFF34FF78.
- Lock: M0 reads 0x100 with lock=1, then writes 0x100 with lock=0, while M1 requests throughout. M1 stays stalled through both M0 transfers and is granted in the next cycle.
- Reset mid-lock: assert `reset_n=0` while M1 owns the lock and a read is in flight. No `readdatavalid` appears, and after reset M0 is granted immediately.

Source files
------------

// File: rtl/nios_ram_arb_pkg.sv
// Shared types and defaults for the two-master nios_ram arbiter.
package nios_ram_arb_pkg;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_M0   = 2'd1,
        LOCK_M1   = 2'd2
    } lock_owner_t;

endpackage

// File: rtl/nios_ram_arb_pick.sv
// Two-way grant picker. Contention policy: round-robin when NIOS_RAM_ARB_RR_EN
// is defined, otherwise fixed priority with master 0 winning.
module nios_ram_arb_pick
    import nios_ram_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  logic        last_grant,
    input  lock_owner_t lock_owner,
    output logic [1:0]  grant
);

    logic [1:0] contend_grant;

`ifdef NIOS_RAM_ARB_RR_EN
    // Hand the tie to whichever master did not win the previous transfer.
    assign contend_grant = last_grant ? 2'b01 : 2'b10;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign contend_grant     = 2'b01;
`endif

    always_comb begin
        grant = 2'b00;
        case (lock_owner)
            LOCK_M0: grant = {1'b0, req[0]};
            LOCK_M1: grant = {req[1], 1'b0};
            default: grant = (&req) ? contend_grant : req;
        endcase
    end

endmodule

// File: rtl/nios_ram_arbiter.sv
// Shares the single-port nios_ram between the Nios II data master (port 0) and
// a DMA master (port 1). Contention policy selected by NIOS_RAM_ARB_RR_EN.
module nios_ram_arbiter #(
    parameter int ADDR_W = nios_ram_arb_pkg::ADDR_W,
    parameter int DATA_W = nios_ram_arb_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    import nios_ram_arb_pkg::*;

    logic [1:0]  rd, wr, lk;
    logic [1:0]  req, grant_raw, grant, wait_req, rdv_next;
    logic [1:0]  rdv_reg;
    logic        last_grant_reg;
    lock_owner_t lock_owner_reg, lock_owner_next;

    assign rd = {m1_read,  m0_read};
    assign wr = {m1_write, m0_write};
    assign lk = {m1_lock,  m0_lock};

    nios_ram_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant_reg),
        .lock_owner (lock_owner_reg),
        .grant      (grant_raw)
    );

    // Nothing is granted while reset is held, so both masters stall.
    assign grant = reset_n ? grant_raw : 2'b00;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req[gi]      = rd[gi] | wr[gi];
        assign wait_req[gi] = ~reset_n | (req[gi] & ~grant[gi]);
        assign rdv_next[gi] = grant[gi] & rd[gi] & ~wr[gi];
    end

    assign m0_waitrequest   = wait_req[0];
    assign m1_waitrequest   = wait_req[1];
    assign m0_readdatavalid = rdv_reg[0];
    assign m1_readdatavalid = rdv_reg[1];
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

    // Port 0 stays on the RAM bus whenever port 1 is not granted.
    assign ram_address    = grant[1] ? m1_address    : m0_address;
    assign ram_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = grant[1] ? m1_writedata  : m0_writedata;
    assign ram_chipselect = |grant;
    assign ram_write      = |(grant & wr);
    assign ram_clken      = reset_n;

    always_comb begin
        lock_owner_next = lock_owner_reg;
        case (lock_owner_reg)
            LOCK_NONE: begin
                if (grant[0] && lk[0])
                    lock_owner_next = LOCK_M0;
                else if (grant[1] && lk[1])
                    lock_owner_next = LOCK_M1;
            end
            LOCK_M0:   if (grant[0] && !lk[0]) lock_owner_next = LOCK_NONE;
            LOCK_M1:   if (grant[1] && !lk[1]) lock_owner_next = LOCK_NONE;
            default:   lock_owner_next = LOCK_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
            lock_owner_reg <= LOCK_NONE;
            rdv_reg        <= 2'b00;
        end else begin
            rdv_reg        <= rdv_next;
            lock_owner_reg <= lock_owner_next;
            if (|grant)
                last_grant_reg <= grant[1];
        end
    end

endmodule
